// File: rtl/trace_plot_sink_if.sv
// Trace-plot sink bus: pixel-write request channel from trace generators and
// the VGA scan-out read channel.
//   wr_x/wr_y/wr_bits/wr_en -> sink, wr_ready <- sink
//   rd_x/rd_y/rd_req        -> sink, rd_valid/rd_bits <- sink
interface trace_plot_sink_if;
    logic [9:0] wr_x;
    logic [8:0] wr_y;
    logic [1:0] wr_bits;
    logic       wr_en;
    logic       wr_ready;
    logic [9:0] rd_x;
    logic [8:0] rd_y;
    logic       rd_req;
    logic       rd_valid;
    logic [1:0] rd_bits;

    modport master (
        output wr_x, wr_y, wr_bits, wr_en, rd_x, rd_y, rd_req,
        input  wr_ready, rd_valid, rd_bits
    );

    modport slave (
        input  wr_x, wr_y, wr_bits, wr_en, rd_x, rd_y, rd_req,
        output wr_ready, rd_valid, rd_bits
    );
endinterface

// File: rtl/trace_plot_sink.sv
// Frame-buffer sink for oscillator traces. Commits pixel writes (2 bits per
// pixel) to a single-port synchronous memory, serves scan-out reads with
// priority over writes, buffers writes in a small FIFO while reads hold the
// memory, and sweeps the whole buffer to 0 after reset.
// Ports:
//   CLOCK_50, reset   clock, synchronous active-high reset
//   bus (slave)       write request channel and scan-out read channel
//   mem_addr/mem_we/mem_wdata/mem_rdata  single-port memory (1-cycle read)
//   clearing          high while the clear sweep runs
//   overflow          sticky dropped-write flag
//   drop_count        saturating dropped-write count
module trace_plot_sink #(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    trace_plot_sink_if.slave  bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata,
    output logic              clearing,
    output logic              overflow,
    output logic [15:0]       drop_count
);

    localparam int unsigned NPIX  = WIDTH * HEIGHT;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NPIX - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]       WIDTH_BITS = 32'(WIDTH);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // y*WIDTH + x as a shift-and-add over the set bits of the constant WIDTH
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(x);
        for (int i = 0; i < 32; i++) begin
            if (WIDTH_BITS[i]) acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [ADDR_W-1:0]   w_clr_ptr_next;

    logic [ENT_W-1:0]    r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic [ENT_W-1:0]    w_head_ent;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_we;
    logic [1:0]          r_mem_wdata;
    logic [ADDR_W-1:0]   w_mem_addr_next;
    logic                w_mem_we_next;
    logic [1:0]          w_mem_wdata_next;

    logic                r_rd_s1;
    logic                r_rd_ok_s1;
    logic                r_rd_s2;
    logic                r_rd_ok_s2;
    logic                r_rd_valid;
    logic [1:0]          r_rd_bits;

    logic                r_wr_ready;
    logic                r_clearing;
    logic                r_overflow;
    logic [15:0]         r_drop_count;

    logic                w_wr_in_range;
    logic                w_rd_in_range;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;

    assign w_wr_in_range = (32'(bus.wr_x) < WIDTH) && (32'(bus.wr_y) < HEIGHT);
    assign w_rd_in_range = (32'(bus.rd_x) < WIDTH) && (32'(bus.rd_y) < HEIGHT);
    assign w_wr_addr     = pix_addr(bus.wr_x, bus.wr_y);
    assign w_rd_addr     = pix_addr(bus.rd_x, bus.rd_y);
    assign w_head_ent    = r_fifo[r_head];

    // Out-of-range writes are dropped at acceptance and never occupy the FIFO
    assign w_push = bus.wr_en && r_wr_ready && w_wr_in_range;
    assign w_drop = bus.wr_en && !w_push;

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) r_state <= S_CLEAR;
        else       r_state <= w_state_next;
    end

    // Next state and memory port arbitration; reads always win the port
    always_comb begin
        w_state_next     = r_state;
        w_clr_ptr_next   = r_clr_ptr;
        w_mem_addr_next  = r_mem_addr;
        w_mem_we_next    = 1'b0;
        w_mem_wdata_next = 2'b00;
        w_pop            = 1'b0;
        case (r_state)
            S_CLEAR: begin
                if (bus.rd_req) begin
                    w_mem_addr_next = w_rd_addr;
                end else begin
                    w_mem_addr_next = r_clr_ptr;
                    w_mem_we_next   = 1'b1;
                    if (r_clr_ptr == LAST_ADDR) w_state_next = S_RUN;
                    else                        w_clr_ptr_next = r_clr_ptr + ADDR_W'(1);
                end
            end
            S_RUN: begin
                if (bus.rd_req) begin
                    w_mem_addr_next = w_rd_addr;
                end else if (r_count != '0) begin
                    w_pop            = 1'b1;
                    w_mem_addr_next  = w_head_ent[ENT_W-1:2];
                    w_mem_we_next    = 1'b1;
                    w_mem_wdata_next = w_head_ent[1:0];
                end
            end
            default: w_state_next = S_CLEAR;
        endcase
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)      w_count_next = r_count + CNT_W'(1);
        else if (!w_push && w_pop) w_count_next = r_count - CNT_W'(1);
    end

    // FIFO storage (contents are don't-care while empty)
    always_ff @(posedge CLOCK_50) begin
        if (w_push) r_fifo[r_tail] <= {w_wr_addr, bus.wr_bits};
    end

    // Datapath and registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_clr_ptr    <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= 2'b00;
            r_rd_s1      <= 1'b0;
            r_rd_ok_s1   <= 1'b0;
            r_rd_s2      <= 1'b0;
            r_rd_ok_s2   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_bits    <= 2'b00;
            r_wr_ready   <= 1'b0;
            r_clearing   <= 1'b1;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_clr_ptr   <= w_clr_ptr_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_count     <= w_count_next;
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);

            // Read pipeline: address goes out now, memory answers next cycle
            r_rd_s1    <= bus.rd_req;
            r_rd_ok_s1 <= bus.rd_req && w_rd_in_range;
            r_rd_s2    <= r_rd_s1;
            r_rd_ok_s2 <= r_rd_ok_s1;
            r_rd_valid <= r_rd_s2;
            r_rd_bits  <= r_rd_ok_s2 ? mem_rdata : 2'b00;

            // Clearing lags the state so it covers the last clear write on the port
            r_clearing <= (r_state == S_CLEAR);
            // Writes open only once that last clear write has retired
            r_wr_ready <= (r_state == S_RUN) && !r_clearing && (w_count_next != FULL_CNT);

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_we       = r_mem_we;
    assign mem_wdata    = r_mem_wdata;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_bits  = r_rd_bits;
    assign bus.wr_ready = r_wr_ready;
    assign clearing     = r_clearing;
    assign overflow     = r_overflow;
    assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_trace_plot_sink.sv
// Self-checking bench for trace_plot_sink on a small 8x4 frame with a
// synchronous behavioural memory and a frame-level reference model.
module tb_trace_plot_sink;
    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned D  = 4;
    localparam int unsigned AW = 5;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [1:0]    mem_wdata;
    logic [1:0]    mem_rdata;
    logic          clearing;
    logic          overflow;
    logic [15:0]   drop_count;

    trace_plot_sink_if bus();

    trace_plot_sink #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .bus        (bus),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .clearing   (clearing),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Single-port synchronous memory, 1-cycle read latency
    logic [1:0] mem [0:31];
    always @(posedge CLOCK_50) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Observers: committed memory writes and returned read data
    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t        wq[$];
    logic [1:0] rq[$];
    int         cyc = 0;
    always @(posedge CLOCK_50) begin
        cyc = cyc + 1;
        if (!reset && mem_we) wq.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
        if (!reset && bus.rd_valid) rq.push_back(bus.rd_bits);
    end

    // Reference model: frame contents and expected drop count
    int ref_fb [0:H-1][0:W-1];
    int exp_drops;
    int tests = 0;
    int fails = 0;

    function automatic int ref_addr(int x, int y);
        return y * int'(W) + x;
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic idle();
        bus.wr_en  = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    task automatic drive_wr(int x, int y, int b);
        bus.wr_x    = 10'(x);
        bus.wr_y    = 9'(y);
        bus.wr_bits = 2'(b);
        bus.wr_en   = 1'b1;
    endtask

    task automatic drive_rd(int x, int y);
        bus.rd_x   = 10'(x);
        bus.rd_y   = 9'(y);
        bus.rd_req = 1'b1;
    endtask

    task automatic zero_model();
        for (int y = 0; y < int'(H); y++)
            for (int x = 0; x < int'(W); x++) ref_fb[y][x] = 0;
    endtask

    // Counts cycles with clearing high; returns 500 if the sweep never ends
    task automatic wait_clear(output int n);
        int g;
        n = 0;
        g = 0;
        while (g < 500) begin
            tick();
            g++;
            if (!clearing) break;
            n++;
        end
        if (g >= 500) n = 500;
    endtask

    // Number of entries in wq that are not the zero write to address i, in order
    function automatic int bad_clear_seq();
        int bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].addr != i || wq[i].data != 0) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        tests++;
        if (clearing !== 1'b1) begin fails++; $display("FAIL reset_clearing got %0b want 1", clearing); end
        tests++;
        if ({mem_we, mem_addr, mem_wdata} !== 8'h00) begin
            fails++; $display("FAIL reset_mem got we=%0b addr=%0d wdata=%0d want 0/0/0", mem_we, mem_addr, mem_wdata);
        end
        tests++;
        if ({bus.wr_ready, bus.rd_valid, bus.rd_bits} !== 4'h0) begin
            fails++; $display("FAIL reset_bus got ready=%0b valid=%0b bits=%0d want 0/0/0", bus.wr_ready, bus.rd_valid, bus.rd_bits);
        end
        tests++;
        if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            fails++; $display("FAIL reset_status got ovf=%0b drops=%0d want 0/0", overflow, drop_count);
        end
    endtask

    task automatic test_clear();
        int n;
        wq.delete();
        reset = 1'b0;
        exp_drops = 0;
        wait_clear(n);
        tests++;
        if (n != int'(W * H)) begin fails++; $display("FAIL clear_cycles got %0d want %0d", n, W * H); end
        tests++;
        if (wq.size() != int'(W * H) || bad_clear_seq() != 0) begin
            fails++; $display("FAIL clear_seq got %0d writes (%0d bad) want %0d zero writes in order", wq.size(), bad_clear_seq(), W * H);
        end
        tests++;
        if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL clear_ready_lag got %0b want 0", bus.wr_ready); end
        tick();
        tests++;
        if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL clear_ready got %0b want 1", bus.wr_ready); end
        zero_model();
    endtask

    task automatic test_write_read();
        drive_wr(3, 2, 2);
        tick();
        idle();
        tests++;
        if (mem_we !== 1'b0) begin fails++; $display("FAIL wr_latency got mem_we=%0b want 0", mem_we); end
        tick();
        tests++;
        if (mem_we !== 1'b1 || int'(mem_addr) != ref_addr(3, 2) || mem_wdata !== 2'b10) begin
            fails++; $display("FAIL wr_commit got we=%0b addr=%0d data=%0d want 1/%0d/2", mem_we, mem_addr, mem_wdata, ref_addr(3, 2));
        end
        ref_fb[2][3] = 2;
        tick();
        drive_rd(3, 2);
        tick();
        idle();
        tests++;
        if (mem_we !== 1'b0 || int'(mem_addr) != ref_addr(3, 2)) begin
            fails++; $display("FAIL rd_addr got we=%0b addr=%0d want 0/%0d", mem_we, mem_addr, ref_addr(3, 2));
        end
        tick();
        tests++;
        if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL rd_early got valid=%0b want 0", bus.rd_valid); end
        tick();
        tests++;
        if (bus.rd_valid !== 1'b1 || int'(bus.rd_bits) != ref_fb[2][3]) begin
            fails++; $display("FAIL rd_data got valid=%0b bits=%0d want 1/%0d", bus.rd_valid, bus.rd_bits, ref_fb[2][3]);
        end
        tick();
    endtask

    task automatic test_range();
        wq.delete();
        drive_wr(8, 0, $urandom_range(0, 3));
        tick();
        drive_wr(0, 4, $urandom_range(0, 3));
        tick();
        idle();
        exp_drops += 2;
        repeat (4) tick();
        tests++;
        if (wq.size() != 0) begin fails++; $display("FAIL range_nowrite got %0d writes want 0", wq.size()); end
        tests++;
        if (int'(drop_count) != exp_drops || overflow !== 1'b1) begin
            fails++; $display("FAIL range_drops got drops=%0d ovf=%0b want %0d/1", drop_count, overflow, exp_drops);
        end
        drive_rd(9, 0);
        tick();
        idle();
        tick();
        tick();
        tests++;
        if (bus.rd_valid !== 1'b1 || bus.rd_bits !== 2'b00) begin
            fails++; $display("FAIL range_read got valid=%0b bits=%0d want 1/0", bus.rd_valid, bus.rd_bits);
        end
        tick();
    endtask

    task automatic test_starve();
        int ax[10], ay[10], ab[10];
        int base, bad;
        logic [1:0] exp_rd[$];
        base = $urandom_range(0, 31);
        rq.delete();
        wq.delete();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            int a, rx, ry;
            a = (base + i * 3) % 32;
            ax[i] = a % int'(W);
            ay[i] = a / int'(W);
            ab[i] = $urandom_range(0, 3);
            rx = $urandom_range(0, W - 1);
            ry = $urandom_range(0, H - 1);
            exp_rd.push_back(2'(ref_fb[ry][rx]));
            // Nothing drains under continuous reads, so only the first D fit
            if (bus.wr_ready !== ((i < int'(D)) ? 1'b1 : 1'b0)) bad++;
            drive_rd(rx, ry);
            drive_wr(ax[i], ay[i], ab[i]);
            tick();
        end
        idle();
        exp_drops += 10 - int'(D);
        tests++;
        if (bad != 0) begin fails++; $display("FAIL starve_ready got %0d wrong ready cycles want 0", bad); end
        tests++;
        if (int'(drop_count) != exp_drops || overflow !== 1'b1) begin
            fails++; $display("FAIL starve_drops got drops=%0d ovf=%0b want %0d/1", drop_count, overflow, exp_drops);
        end
        repeat (8) tick();
        tests++;
        if (wq.size() != int'(D)) begin fails++; $display("FAIL starve_commits got %0d want %0d", wq.size(), D); end
        for (int i = 0; i < int'(D) && i < wq.size(); i++) begin
            tests++;
            if (wq[i].addr != ref_addr(ax[i], ay[i]) || wq[i].data != ab[i] || (i > 0 && wq[i].cyc != wq[i-1].cyc + 1)) begin
                fails++; $display("FAIL starve_order[%0d] got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d consecutive",
                                  i, wq[i].addr, wq[i].data, wq[i].cyc, ref_addr(ax[i], ay[i]), ab[i]);
            end
            ref_fb[ay[i]][ax[i]] = ab[i];
        end
        tests++;
        if (rq.size() != 10) begin fails++; $display("FAIL starve_reads got %0d want 10", rq.size()); end
        for (int i = 0; i < 10 && i < rq.size(); i++) begin
            tests++;
            if (rq[i] !== exp_rd[i]) begin fails++; $display("FAIL starve_rd[%0d] got %0d want %0d", i, rq[i], exp_rd[i]); end
        end
    endtask

    task automatic test_random();
        int bad_ready;
        logic [1:0] exp_rd[$];
        bad_ready = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if ($urandom_range(0, 3) != 0) begin
                int x, y, b;
                x = $urandom_range(0, W + 1);
                y = $urandom_range(0, H);
                b = $urandom_range(0, 3);
                // Without reads the FIFO drains every cycle and never fills
                if (bus.wr_ready !== 1'b1) bad_ready++;
                drive_wr(x, y, b);
                if (x < int'(W) && y < int'(H)) ref_fb[y][x] = b;
                else exp_drops++;
            end
            tick();
        end
        idle();
        repeat (4) tick();
        tests++;
        if (bad_ready != 0) begin fails++; $display("FAIL rand_ready got %0d stalls want 0", bad_ready); end
        tests++;
        if (int'(drop_count) != exp_drops) begin fails++; $display("FAIL rand_drops got %0d want %0d", drop_count, exp_drops); end
        rq.delete();
        for (int a = 0; a <= int'(W * H); a++) begin
            if (a == int'(W * H)) begin
                drive_rd(W, 0);
                exp_rd.push_back(2'b00);
            end else begin
                drive_rd(a % int'(W), a / int'(W));
                exp_rd.push_back(2'(ref_fb[a / int'(W)][a % int'(W)]));
            end
            tick();
        end
        idle();
        repeat (4) tick();
        tests++;
        if (rq.size() != exp_rd.size()) begin fails++; $display("FAIL rand_reads got %0d want %0d", rq.size(), exp_rd.size()); end
        for (int i = 0; i < exp_rd.size() && i < rq.size(); i++) begin
            tests++;
            if (rq[i] !== exp_rd[i]) begin fails++; $display("FAIL rand_rd[%0d] got %0d want %0d", i, rq[i], exp_rd[i]); end
        end
    endtask

    task automatic test_clear_read();
        int n, n2, bad;
        reset = 1'b1;
        idle();
        tick();
        tick();
        exp_drops = 0;
        wq.delete();
        rq.delete();
        reset = 1'b0;
        n = 0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i % 3 == 0) begin
                drive_wr($urandom_range(0, W - 1), $urandom_range(0, H - 1), 3);
                exp_drops++;
            end
            tick();
            if (clearing) n++;
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            drive_rd(i, 0);
            tick();
            if (clearing) n++;
            if (mem_we !== 1'b0 || int'(mem_addr) != ref_addr(i, 0)) bad++;
        end
        idle();
        wait_clear(n2);
        tests++;
        if (n + n2 != int'(W * H) + 5) begin fails++; $display("FAIL clrd_cycles got %0d want %0d", n + n2, W * H + 5); end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL clrd_port got %0d bad read cycles want 0", bad); end
        tests++;
        if (wq.size() != int'(W * H) || bad_clear_seq() != 0) begin
            fails++; $display("FAIL clrd_seq got %0d writes (%0d bad) want %0d zero writes in order", wq.size(), bad_clear_seq(), W * H);
        end
        tests++;
        if (rq.size() != 5 || rq[0] !== 2'b00 || rq[4] !== 2'b00) begin
            fails++; $display("FAIL clrd_reads got %0d results want 5 zeros", rq.size());
        end
        tests++;
        if (int'(drop_count) != exp_drops) begin fails++; $display("FAIL clrd_drops got %0d want %0d", drop_count, exp_drops); end
        zero_model();
    endtask

    task automatic test_reset_mid();
        int n, bad;
        tick();
        drive_rd($urandom_range(0, W - 1), $urandom_range(0, H - 1));
        for (int i = 0; i < 3; i++) begin
            drive_wr($urandom_range(0, W - 1), $urandom_range(0, H - 1), 3);
            tick();
        end
        bus.wr_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tests++;
        if (drop_count !== 16'd0 || overflow !== 1'b0 || clearing !== 1'b1 || bus.wr_ready !== 1'b0 || mem_we !== 1'b0) begin
            fails++; $display("FAIL rstmid_state got drops=%0d ovf=%0b clr=%0b ready=%0b we=%0b want 0/0/1/0/0",
                              drop_count, overflow, clearing, bus.wr_ready, mem_we);
        end
        idle();
        wq.delete();
        rq.delete();
        reset = 1'b0;
        wait_clear(n);
        repeat (6) tick();
        tests++;
        if (n != int'(W * H)) begin fails++; $display("FAIL rstmid_cycles got %0d want %0d", n, W * H); end
        bad = bad_clear_seq();
        tests++;
        if (wq.size() != int'(W * H) || bad != 0) begin
            fails++; $display("FAIL rstmid_seq got %0d writes (%0d bad) want %0d zero writes only", wq.size(), bad, W * H);
        end
        tests++;
        if (rq.size() != 0 || drop_count !== 16'd0) begin
            fails++; $display("FAIL rstmid_flush got reads=%0d drops=%0d want 0/0", rq.size(), drop_count);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.wr_x    = '0;
        bus.wr_y    = '0;
        bus.wr_bits = '0;
        bus.wr_en   = 1'b0;
        bus.rd_x    = '0;
        bus.rd_y    = '0;
        bus.rd_req  = 1'b0;
        exp_drops   = 0;
        zero_model();
        @(negedge CLOCK_50);
        test_reset();
        test_clear();
        test_write_read();
        test_range();
        test_starve();
        test_random();
        test_clear_read();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule
